// File: rtl/l1_buffer_stream_reader_if.sv
// Row stream from the L1 buffer reader toward the PE array (valid/ready).
// The master drives rows out; the slave accepts them with out_ready.
interface l1_buffer_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_COUNT = 4
);
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH*LANE_COUNT-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/l1_buffer_stream_reader.sv
// Read sequencer for an L1_buffer: issues a wrapped run of row reads and streams rows through a 2-entry skid FIFO.
// Defining L1_READER_ABORT_EN adds an 'abort' input that cancels a run without a done pulse.
module l1_buffer_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_COUNT = 4,
    parameter int DATA_DEPTH = 16,
    localparam int IW = $clog2(DATA_DEPTH),
    localparam int LW = $clog2(DATA_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [IW-1:0]                    base_index,
    input  logic [LW-1:0]                    length,
    output logic                             busy,
    output logic                             done,
    output logic                             buf_enable,
    output logic                             buf_write,
    output logic [IW-1:0]                    buf_index,
    input  logic [DATA_WIDTH*LANE_COUNT-1:0] buf_data_out,
`ifdef L1_READER_ABORT_EN
    input  logic                             abort,
`endif
    l1_buffer_stream_reader_if.master        stream
);
    localparam int RW = DATA_WIDTH * LANE_COUNT;
    localparam logic [LW-1:0] DEPTH_LEN = LW'(DATA_DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    logic [IW-1:0] rd_ptr;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic [1:0]    count;
    logic [RW-1:0] head;
    logic [RW-1:0] tail;
    logic          pop;
    logic          issue;
    logic          abort_hit;
    logic [LW-1:0] start_len;

    assign pop = (count != 2'd0) && stream.out_ready;

    // Only issue when the row can land: FIFO plus in-flight read, net of this cycle's pop, stays below 2.
    assign issue = (state == RUN) && (remaining != '0)
                 && (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef L1_READER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign start_len        = (length > DEPTH_LEN) ? DEPTH_LEN : length;
    assign buf_enable       = issue;
    assign buf_write        = 1'b0;
    assign buf_index        = issue ? rd_ptr : '0;
    assign stream.out_valid = (count != 2'd0);
    assign stream.out_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_ptr    <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (abort_hit) begin
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= '0;
                inflight  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rd_ptr    <= base_index;
                            remaining <= start_len;
                            busy      <= 1'b1;
                            state     <= (start_len == '0) ? DRAIN : RUN;
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            rd_ptr    <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + IW'(1);
                            remaining <= remaining - LW'(1);
                            if (remaining == LW'(1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        // Finish on the edge that pops the last buffered row so done lands right after it.
                        if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Two-entry skid FIFO: head is the presented row, tail holds the row that arrives while head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (abort_hit) begin
            count <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= buf_data_out;
                    end else begin
                        tail <= buf_data_out;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= buf_data_out;
                    end else begin
                        head <= tail;
                        tail <= buf_data_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_buffer_stream_reader.sv
// Self-checking bench for l1_buffer_stream_reader: directed vector table, reset/abort sequences, randomized runs.
// Abort checks are compiled in when L1_READER_ABORT_EN is defined.
module tb_l1_buffer_stream_reader;
    localparam int DW = 8;
    localparam int LC = 4;
    localparam int DD = 16;
    localparam int IW = 4;
    localparam int LW = 5;
    localparam int RW = DW * LC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] base_index = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic          buf_enable;
    logic          buf_write;
    logic [IW-1:0] buf_index;
    logic [RW-1:0] buf_data_out;
`ifdef L1_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    l1_buffer_stream_reader_if #(.DATA_WIDTH(DW), .LANE_COUNT(LC)) stream ();

    l1_buffer_stream_reader #(
        .DATA_WIDTH(DW),
        .LANE_COUNT(LC),
        .DATA_DEPTH(DD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_index(base_index),
        .length(length),
        .busy(busy),
        .done(done),
        .buf_enable(buf_enable),
        .buf_write(buf_write),
        .buf_index(buf_index),
        .buf_data_out(buf_data_out),
`ifdef L1_READER_ABORT_EN
        .abort(abort),
`endif
        .stream(stream)
    );

    always #5 clk = ~clk;

    // L1 buffer model: one-cycle registered read; garbage on idle cycles exposes mistimed captures.
    logic [RW-1:0] mem [DD];
    always @(posedge clk) begin
        if (buf_enable && !buf_write) begin
            buf_data_out <= mem[buf_index];
        end else begin
            buf_data_out <= RW'($urandom);
        end
    end

    typedef struct {
        int base;
        int len;
        int mode;
        int expRows;
        int expDone;
        bit injectStart;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic readyFor(input int mode, input int k);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0: return 1'b1;
            1: return pat[k % 4];
            default: return ($urandom_range(0, 99) < 60);
        endcase
    endfunction

    // Expected rows come from the buffer contents at (base + i) mod depth for min(len, depth) rows.
    task automatic applyStimulus(input int base, input int len, input int mode,
                                 input int expRows, input int expDone, input bit injectStart);
        logic [IW-1:0] expIdx[$];
        logic [RW-1:0] expRow[$];
        logic [RW-1:0] prevData;
        int n, issued, popped, doneAt, firstValid;
        bit prevStall;
        logic v, r, popNow;

        n = (len > DD) ? DD : len;
        for (int i = 0; i < n; i++) begin
            expIdx.push_back(IW'((base + i) % DD));
            expRow.push_back(mem[(base + i) % DD]);
        end

        @(negedge clk);
        start = 1'b1;
        base_index = IW'(base);
        length = LW'(len);
        stream.out_ready = readyFor(mode, 0);
        #1;
        checkOutput("idle_no_issue", longint'(buf_enable), 0);

        issued = 0;
        popped = 0;
        doneAt = -1;
        firstValid = -1;
        prevStall = 1'b0;
        prevData = '0;
        for (int k = 1; k <= 300 && doneAt < 0; k++) begin
            @(negedge clk);
            start = injectStart && (k == 2);
            stream.out_ready = readyFor(mode, k);
            #1;
            v = stream.out_valid;
            r = stream.out_ready;
            popNow = v & r;
            if (prevStall) begin
                checkOutput("stall_valid", longint'(v), 1);
                checkOutput("stall_data", longint'(stream.out_data), longint'(prevData));
            end
            if (v && firstValid < 0) firstValid = k;
            if (buf_enable) begin
                checkOutput("no_overflow", longint'((issued - popped - int'(popNow)) < 2), 1);
                if (expIdx.size() != 0) begin
                    checkOutput("buf_index", longint'(buf_index), longint'(expIdx.pop_front()));
                end else begin
                    checkOutput("issue_limit", longint'(issued + 1), longint'(n));
                end
                issued++;
            end
            checkOutput("buf_write", longint'(buf_write), 0);
            if (popNow) begin
                if (expRow.size() != 0) begin
                    checkOutput("row_data", longint'(stream.out_data), longint'(expRow.pop_front()));
                end else begin
                    checkOutput("row_limit", longint'(popped + 1), longint'(n));
                end
                popped++;
            end
            if (done) begin
                doneAt = k;
                checkOutput("busy_at_done", longint'(busy), 0);
                checkOutput("rows_delivered", longint'(popped), longint'(expRows));
            end else begin
                checkOutput("busy_in_run", longint'(busy), 1);
            end
            prevStall = v && !r;
            prevData = stream.out_data;
        end
        start = 1'b0;

        checkOutput("done_seen", longint'(doneAt >= 0), 1);
        if (expDone >= 0) checkOutput("done_cycle", longint'(doneAt), longint'(expDone));
        if (mode == 0 && expRows > 0) checkOutput("first_valid", longint'(firstValid), 3);

        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1;
            checkOutput("done_single_pulse", longint'(done), 0);
            checkOutput("idle_valid", longint'(stream.out_valid), 0);
            checkOutput("idle_enable", longint'(buf_enable), 0);
        end
    endtask

    initial begin
        int pops;
        logic [7:0] b;

        stream.out_ready = 1'b0;
        for (int r = 0; r < DD; r++) begin
            b = r[7:0];
            mem[r] = {LC{b}};
        end

        vecs[0] = '{base: 3,  len: 5,  mode: 0, expRows: 5,  expDone: 8,  injectStart: 1'b0};
        vecs[1] = '{base: 14, len: 4,  mode: 0, expRows: 4,  expDone: 7,  injectStart: 1'b0};
        vecs[2] = '{base: 2,  len: 6,  mode: 1, expRows: 6,  expDone: -1, injectStart: 1'b0};
        vecs[3] = '{base: 0,  len: 0,  mode: 0, expRows: 0,  expDone: 2,  injectStart: 1'b0};
        vecs[4] = '{base: 7,  len: 4,  mode: 0, expRows: 4,  expDone: 7,  injectStart: 1'b1};
        vecs[5] = '{base: 9,  len: 16, mode: 0, expRows: 16, expDone: 19, injectStart: 1'b0};
        vecs[6] = '{base: 5,  len: 20, mode: 0, expRows: 16, expDone: 19, injectStart: 1'b0};
        vecs[7] = '{base: 15, len: 1,  mode: 0, expRows: 1,  expDone: 4,  injectStart: 1'b0};

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_done", longint'(done), 0);
        checkOutput("reset_enable", longint'(buf_enable), 0);
        checkOutput("reset_write", longint'(buf_write), 0);
        checkOutput("reset_valid", longint'(stream.out_valid), 0);
        checkOutput("reset_index", longint'(buf_index), 0);
        checkOutput("reset_data", longint'(stream.out_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d base=%0d len=%0d mode=%0d", i, vecs[i].base, vecs[i].len, vecs[i].mode);
            applyStimulus(vecs[i].base, vecs[i].len, vecs[i].mode,
                          vecs[i].expRows, vecs[i].expDone, vecs[i].injectStart);
        end

        // Asynchronous reset in the middle of a run, once two rows have been taken.
        @(negedge clk);
        start = 1'b1;
        base_index = '0;
        length = LW'(8);
        stream.out_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 20 && pops < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (stream.out_valid && stream.out_ready) pops++;
        end
        checkOutput("reset_prep_pops", longint'(pops), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_busy", longint'(busy), 0);
        checkOutput("midrun_reset_done", longint'(done), 0);
        checkOutput("midrun_reset_enable", longint'(buf_enable), 0);
        checkOutput("midrun_reset_valid", longint'(stream.out_valid), 0);
        checkOutput("midrun_reset_data", longint'(stream.out_data), 0);
        checkOutput("midrun_reset_index", longint'(buf_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(10, 2, 0, 2, 5, 1'b0);

`ifdef L1_READER_ABORT_EN
        @(negedge clk);
        start = 1'b1;
        base_index = IW'(4);
        length = LW'(8);
        stream.out_ready = 1'b1;
        pops = 0;
        for (int k = 0; k < 20 && pops < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (stream.out_valid && stream.out_ready) pops++;
        end
        checkOutput("abort_prep_pops", longint'(pops), 3);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_valid", longint'(stream.out_valid), 0);
        checkOutput("abort_busy", longint'(busy), 0);
        for (int j = 0; j < 4; j++) begin
            checkOutput("abort_no_done", longint'(done), 0);
            checkOutput("abort_no_issue", longint'(buf_enable), 0);
            @(negedge clk);
            #1;
        end
        applyStimulus(1, 3, 0, 3, 6, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            int rb, rl;
            for (int r = 0; r < DD; r++) mem[r] = RW'($urandom);
            rb = $urandom_range(0, DD - 1);
            rl = $urandom_range(0, DD + 4);
            applyStimulus(rb, rl, 2, (rl > DD) ? DD : rl, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
